// File: rtl/multi_edge_detect_pkg.sv
// edge_pkg: edge-mode type, default channel parameters and the mode qualifier helper
package edge_pkg;
  typedef enum logic [1:0] {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH} edge_mode_t;
  localparam int DEF_N_CH = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  function automatic logic mode_allows(edge_mode_t m, logic rise);
    return rise ? (m == EDGE_RISE || m == EDGE_BOTH) : (m == EDGE_FALL || m == EDGE_BOTH);
  endfunction
endpackage

// File: rtl/multi_edge_detect_if.sv
// multi_edge_detect_if: per-channel level/mode/clear inputs and tick/pending status outputs
interface multi_edge_detect_if #(parameter int N_CH = 4);
  logic [N_CH-1:0] level, clear, tick, pending;
  logic [2*N_CH-1:0] mode;
  logic any_pending;
  modport master(output level, mode, clear, input tick, pending, any_pending);
  modport slave(input level, mode, clear, output tick, pending, any_pending);
endinterface

// File: rtl/multi_edge_detect_channel.sv
// edge_channel: one channel of synchroniser, debounce filter, edge qualifier and sticky pending flag
module edge_channel import edge_pkg::*; #(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       level,
  input  edge_mode_t mode,
  input  logic       clear,
  output logic       tick,
  output logic       pending,
  output logic       pending_next
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic filt_q, filt_d, tick_q, tick_d, pending_q, pending_d;
  logic sync_out, upd;
  assign sync_out = sync_q[SYNC_STAGES-1];
  // filt only moves once sync_out has disagreed with it for DEBOUNCE_CYCLES straight cycles
  assign upd = (sync_out != filt_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], level};
    cnt_d = (sync_out == filt_q || upd) ? '0 : cnt_q + 1'b1;
    filt_d = upd ? sync_out : filt_q;
    tick_d = upd && mode_allows(mode, sync_out);
    pending_d = tick_d | (pending_q & ~clear);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q <= '0;
      filt_q <= 1'b0;
      tick_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      filt_q <= filt_d;
      tick_q <= tick_d;
      pending_q <= pending_d;
    end
  assign tick = tick_q;
  assign pending = pending_q;
  assign pending_next = pending_d;
endmodule

// File: rtl/multi_edge_detect.sv
// multi_edge_detect: N independent debounced edge-detect channels plus a registered any-pending summary
module multi_edge_detect import edge_pkg::*; #(
  parameter int N_CH = DEF_N_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)(
  input logic clk,
  input logic reset_n,
  multi_edge_detect_if.slave bus
);
  logic [N_CH-1:0] pending_next;
  logic any_pending_q, any_pending_d;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .level(bus.level[i]),
      .mode(edge_mode_t'(bus.mode[2*i+:2])),
      .clear(bus.clear[i]),
      .tick(bus.tick[i]),
      .pending(bus.pending[i]),
      .pending_next(pending_next[i])
    );
  end
  // summarise the next-state flags so any_pending switches on the same edge as pending
  always_comb any_pending_d = |pending_next;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) any_pending_q <= 1'b0;
    else any_pending_q <= any_pending_d;
  assign bus.any_pending = any_pending_q;
endmodule

// File: tb/tb_multi_edge_detect.sv
// tb_multi_edge_detect: directed and random stimulus against a sample-history reference model
module tb_multi_edge_detect;
  localparam int N = 4, S = 2, D = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  multi_edge_detect_if #(.N_CH(N)) bus();
  multi_edge_detect #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  int tests = 0, fails = 0;
  logic [31:0] hist [N];
  logic [N-1:0] m_filt, m_tick, m_pend, lv, clr;
  logic m_any;
  logic [2*N-1:0] md;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) hist[i] = '0;
    m_filt = '0; m_tick = '0; m_pend = '0; m_any = 1'b0;
  endtask

  // filt flips when the last D synchronised samples all disagree with it
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      logic [D-1:0] w;
      logic [1:0] mi;
      logic upd;
      hist[i] = {hist[i][30:0], lv[i]};
      w = D'(hist[i] >> S);
      upd = m_filt[i] ? (w == '0) : (w == '1);
      mi = md[2*i+:2];
      m_tick[i] = upd & (m_filt[i] ? mi[1] : mi[0]);
      if (upd) m_filt[i] = ~m_filt[i];
      m_pend[i] = m_tick[i] | (m_pend[i] & ~clr[i]);
    end
    m_any = |m_pend;
  endtask

  task automatic step(input logic [N-1:0] l, input logic [2*N-1:0] m, input logic [N-1:0] c);
    @(negedge clk);
    lv = l; md = m; clr = c;
    bus.level = l; bus.mode = m; bus.clear = c;
    @(posedge clk);
    model_step();
    #1;
    check("tick", bus.tick, m_tick);
    check("pending", bus.pending, m_pend);
    check("any_pending", N'(bus.any_pending), N'(m_any));
  endtask

  task automatic run(input int n, input logic [N-1:0] l, input logic [2*N-1:0] m,
                     input logic [N-1:0] c, input int ch, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      step(l, m, c);
      cnt += int'(bus.tick[ch]);
    end
  endtask

  initial begin
    int a, b;
    logic [N-1:0] rl, rc;
    logic [2*N-1:0] rm;
    bus.level = '0; bus.mode = '0; bus.clear = '0;
    lv = '0; md = '0; clr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_tick", bus.tick, '0);
    check("reset_pending", bus.pending, '0);
    check("reset_any", N'(bus.any_pending), '0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(4'b0001, 8'h01, '0);
      if (k == 6) check("t1_tick_edge6", bus.tick, 4'b0001);
      if (k == 7) begin
        check("t1_tick_one_cycle", bus.tick, '0);
        check("t1_pending", bus.pending, 4'b0001);
        check("t1_any", N'(bus.any_pending), N'(1));
      end
    end
    run(10, 4'b0011, 8'h0D, '0, 1, a);
    run(10, 4'b0001, 8'h0D, '0, 1, b);
    check("t2_both_ticks", N'(a + b), N'(2));
    run(3, 4'b0101, 8'h3D, '0, 2, a);
    run(8, 4'b0001, 8'h3D, '0, 2, b);
    check("t3_glitch_ticks", N'(a + b), '0);
    check("t3_glitch_pending", N'(bus.pending[2]), '0);
    run(4, 4'b0101, 8'h3D, '0, 2, a);
    run(8, 4'b0001, 8'h3D, '0, 2, b);
    check("t3_pulse_ticks", N'(a + b), N'(2));
    run(8, 4'b1001, 8'hBD, '0, 3, a);
    run(8, 4'b0001, 8'hBD, '0, 3, b);
    check("t4_fall_only", N'(a + b), N'(1));
    run(8, 4'b1001, 8'h3D, '0, 3, a);
    run(8, 4'b0001, 8'h3D, '0, 3, b);
    check("t4_off_ticks", N'(a + b), '0);
    run(8, 4'b0001, 8'hFD, '0, 3, a);
    check("t4_enable_no_spurious", N'(a), '0);
    step(4'b0001, 8'hFD, 4'hF);
    check("clear_all_any", N'(bus.any_pending), '0);
    run(6, 4'b0000, 8'hFF, '0, 0, a);
    check("t5_fall_tick", N'(a), N'(1));
    run(5, 4'b0001, 8'hFF, '0, 0, a);
    step(4'b0001, 8'hFF, 4'b0001);
    check("t5_tick_with_clear", N'(bus.tick[0]), N'(1));
    check("t5_set_wins", N'(bus.pending[0]), N'(1));
    step(4'b0001, 8'hFF, 4'b0001);
    check("t5_cleared", bus.pending, '0);
    check("t5_any_cleared", N'(bus.any_pending), '0);
    run(4, 4'b1111, 8'hFF, '0, 0, a);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_tick", bus.tick, '0);
    check("t6_async_pending", bus.pending, '0);
    check("t6_async_any", N'(bus.any_pending), '0);
    model_reset();
    @(posedge clk);
    #1;
    check("t6_held_tick", bus.tick, '0);
    check("t6_held_pending", bus.pending, '0);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(4'b1111, 8'hFF, '0);
      if (k == 5) check("t6_no_early_tick", bus.tick, '0);
      if (k == 6) check("t6_tick_edge6", bus.tick, 4'b1111);
    end
    rl = 4'b1111;
    rm = 8'hFF;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(4) == 0) rl[i] = ~rl[i];
      if (k % 25 == 0) rm = 8'($urandom);
      rc = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) rc[i] = 1'b1;
      step(rl, rm, rc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
